weighted_resource_scheduler: RTL and testbench

- Shares the single shared_resource between pipeline_1 and pipeline_2 using weighted round-robin grants.
- Also applies a credit limit on outstanding resource requests and masks requesters during pipeline flushes.
- Sits between the pipeline outputs and shared_resource, and replaces the plain two-way arbiter.
- Drives the resource address/ID mux select, the resource valid, and the per-pipeline stalls.

---
 rtl/weighted_resource_scheduler.sv | 146 ++++++++++++++
 tb/tb_weighted_resource_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_resource_scheduler.sv
// Weighted round-robin grant of one shared resource between two pipelines,
// with an outstanding-request credit limit and per-pipeline flush masking.
module weighted_resource_scheduler #(
  parameter int WEIGHT_1        = 2,
  parameter int WEIGHT_2        = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_1,
  input  logic             in_valid_2,
  input  logic             in_flush_1,
  input  logic             in_flush_2,
  input  logic             in_flush_done_1,
  input  logic             in_flush_done_2,
  input  logic             in_ready,
  input  logic             in_resp_valid,
  output logic             out_valid,
  output logic             out_choice,
  output logic             out_stall_1,
  output logic             out_stall_2,
  output logic [CNT_W-1:0] out_outstanding,
  output logic             out_error
);

  localparam logic [CNT_W-1:0] W1  = CNT_W'(WEIGHT_1);
  localparam logic [CNT_W-1:0] W2  = CNT_W'(WEIGHT_2);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             mask_1_q, mask_1_d;
  logic             mask_2_q, mask_2_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             err_q, err_d;
  logic             choice_q, choice_d;

  logic             elig_1, elig_2;
  logic             credit_ok, issue;
  logic             choice;
  logic             grant_1, grant_2;
  logic [CNT_W-1:0] wgt;

  always_comb begin
    elig_1    = in_valid_1 & ~in_flush_1 & ~mask_1_q;
    elig_2    = in_valid_2 & ~in_flush_2 & ~mask_2_q;
    credit_ok = outst_q < MAX;
    issue     = (elig_1 | elig_2) & credit_ok & in_ready;

    // With no eligible requester the last choice is simply held
    if (elig_1 && elig_2) begin
      choice = ptr_q;
    end else if (elig_2) begin
      choice = 1'b1;
    end else if (elig_1) begin
      choice = 1'b0;
    end else begin
      choice = choice_q;
    end

    grant_1  = issue & ~choice;
    grant_2  = issue & choice;
    choice_d = choice;
    wgt      = choice ? W2 : W1;
  end

  always_comb begin
    ptr_d   = ptr_q;
    burst_d = burst_q;
    if (issue) begin
      if (choice == ptr_q) begin
        if (burst_q + ONE == wgt) begin
          ptr_d   = ~choice;
          burst_d = '0;
        end else begin
          burst_d = burst_q + ONE;
        end
      end else if (wgt == ONE) begin
        ptr_d   = ~choice;
        burst_d = '0;
      end else begin
        ptr_d   = choice;
        burst_d = ONE;
      end
    end
  end

  always_comb begin
    mask_1_d = mask_1_q ? (in_flush_1 | ~in_flush_done_1) : in_flush_1;
    mask_2_d = mask_2_q ? (in_flush_2 | ~in_flush_done_2) : in_flush_2;
  end

  always_comb begin
    outst_d = outst_q;
    err_d   = err_q;
    if (in_resp_valid && outst_q == '0) begin
      err_d = 1'b1;
    end
    if (issue && !in_resp_valid) begin
      outst_d = outst_q + ONE;
    end else if (!issue && in_resp_valid && outst_q != '0) begin
      outst_d = outst_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q    <= 1'b0;
      burst_q  <= '0;
      mask_1_q <= 1'b0;
      mask_2_q <= 1'b0;
      outst_q  <= '0;
      err_q    <= 1'b0;
      choice_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
      mask_1_q <= mask_1_d;
      mask_2_q <= mask_2_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      choice_q <= choice_d;
    end
  end

  always_comb begin
    if (!reset) begin
      out_valid       = 1'b0;
      out_choice      = 1'b0;
      out_stall_1     = 1'b1;
      out_stall_2     = 1'b1;
      out_outstanding = '0;
      out_error       = 1'b0;
    end else begin
      out_valid       = issue;
      out_choice      = choice;
      out_stall_1     = (in_valid_1 & ~grant_1) | in_flush_1 | mask_1_q;
      out_stall_2     = (in_valid_2 & ~grant_2) | in_flush_2 | mask_2_q;
      out_outstanding = outst_q;
      out_error       = err_q;
    end
  end

endmodule

// File: tb/tb_weighted_resource_scheduler.sv
// Directed bench for weighted_resource_scheduler: weights, credit,
// flush masking, error flag and reset behaviour.
module tb_weighted_resource_scheduler;

  logic       clk;
  logic       rst;
  logic       v1, v2, f1, f2, d1, d2, rdy, resp;
  logic       o_valid, o_choice, o_st1, o_st2, o_err;
  logic [3:0] o_out;

  int passed;
  int total;

  weighted_resource_scheduler #(
    .WEIGHT_1(2),
    .WEIGHT_2(1),
    .MAX_OUTSTANDING(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(rst),
    .in_valid_1(v1),
    .in_valid_2(v2),
    .in_flush_1(f1),
    .in_flush_2(f2),
    .in_flush_done_1(d1),
    .in_flush_done_2(d2),
    .in_ready(rdy),
    .in_resp_valid(resp),
    .out_valid(o_valid),
    .out_choice(o_choice),
    .out_stall_1(o_st1),
    .out_stall_2(o_st2),
    .out_outstanding(o_out),
    .out_error(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    v1 = 0; v2 = 0; f1 = 0; f2 = 0;
    d1 = 0; d2 = 0; rdy = 1; resp = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0; v1 = 1; v2 = 1; rdy = 1; resp = 0;
    #1;
    total++;
    if (o_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", o_valid);
    else passed++;
    total++;
    if (o_choice !== 1'b0) $display("FAIL rst_choice got %b want 0", o_choice);
    else passed++;
    total++;
    if ({o_st1, o_st2} !== 2'b11)
      $display("FAIL rst_stalls got %b%b want 11", o_st1, o_st2);
    else passed++;
    total++;
    if (o_out !== 4'd0) $display("FAIL rst_outst got %0d want 0", o_out);
    else passed++;
    total++;
    if (o_err !== 1'b0) $display("FAIL rst_err got %b want 0", o_err);
    else passed++;
    @(negedge clk);
    rst = 1;
    idle_inputs();
    #1;
    total++;
    if (o_out !== 4'd0 || o_valid !== 1'b0)
      $display("FAIL post_rst got out=%0d valid=%b want 0/0", o_out, o_valid);
    else passed++;
  endtask

  task automatic test_weights();
    logic [5:0] pat;
    pat = 6'b100100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v1 = 1; v2 = 1; rdy = 1; resp = (i > 0);
      #1;
      total++;
      if (o_valid !== 1'b1 || o_choice !== pat[i])
        $display("FAIL wrr_choice[%0d] got v=%b c=%b want v=1 c=%b",
                 i, o_valid, o_choice, pat[i]);
      else passed++;
      total++;
      if (o_st1 !== pat[i] || o_st2 !== ~pat[i])
        $display("FAIL wrr_stall[%0d] got %b%b want %b%b",
                 i, o_st1, o_st2, pat[i], ~pat[i]);
      else passed++;
    end
    @(negedge clk);
    v1 = 0; v2 = 0; resp = 1;
    @(negedge clk);
    resp = 0;
    #1;
    total++;
    if (o_out !== 4'd0 || o_err !== 1'b0)
      $display("FAIL wrr_drain got out=%0d err=%b want 0/0", o_out, o_err);
    else passed++;
  endtask

  task automatic test_only_p2();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v1 = 0; v2 = 1; resp = 0;
      #1;
      total++;
      if (o_valid !== 1'b1 || o_choice !== 1'b1)
        $display("FAIL p2_only[%0d] got v=%b c=%b want 1/1", i, o_valid, o_choice);
      else passed++;
      total++;
      if (o_st1 !== 1'b0 || o_st2 !== 1'b0)
        $display("FAIL p2_stall[%0d] got %b%b want 00", i, o_st1, o_st2);
      else passed++;
    end
    @(negedge clk);
    v1 = 1; v2 = 1;
    #1;
    total++;
    if (o_valid !== 1'b1 || o_choice !== 1'b0 || o_st2 !== 1'b1)
      $display("FAIL p2_then_both got v=%b c=%b st2=%b want 1/0/1",
               o_valid, o_choice, o_st2);
    else passed++;
    @(negedge clk);
    v1 = 0; v2 = 0;
    #1;
    total++;
    if (o_out !== 4'd4) $display("FAIL p2_outst got %0d want 4", o_out);
    else passed++;
  endtask

  task automatic test_credit();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v1 = 1; v2 = 1; resp = 0;
      #1;
      total++;
      if (o_valid !== 1'b1) $display("FAIL credit_grant[%0d] got %b want 1", i, o_valid);
      else passed++;
    end
    @(negedge clk);
    #1;
    total++;
    if (o_valid !== 1'b0 || o_out !== 4'd4)
      $display("FAIL credit_full got v=%b out=%0d want 0/4", o_valid, o_out);
    else passed++;
    total++;
    if ({o_st1, o_st2} !== 2'b11)
      $display("FAIL credit_stalls got %b%b want 11", o_st1, o_st2);
    else passed++;
    @(negedge clk);
    resp = 1;
    #1;
    total++;
    if (o_valid !== 1'b0) $display("FAIL credit_resp_cycle got %b want 0", o_valid);
    else passed++;
    @(negedge clk);
    resp = 0;
    #1;
    total++;
    if (o_valid !== 1'b1 || o_choice !== 1'b0 || o_out !== 4'd3)
      $display("FAIL credit_regrant got v=%b c=%b out=%0d want 1/0/3",
               o_valid, o_choice, o_out);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (o_valid !== 1'b0 || o_out !== 4'd4)
      $display("FAIL credit_refull got v=%b out=%0d want 0/4", o_valid, o_out);
    else passed++;
  endtask

  task automatic test_flush();
    logic [4:0] ch;
    ch = 5'b01111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      v1 = 1; v2 = 1;
      f1 = (c == 0); d1 = (c == 3); resp = (c > 0);
      #1;
      total++;
      if (o_valid !== 1'b1 || o_choice !== ch[c])
        $display("FAIL flush_choice[%0d] got v=%b c=%b want 1/%b",
                 c, o_valid, o_choice, ch[c]);
      else passed++;
      total++;
      if (o_st1 !== ch[c] || o_st2 !== ~ch[c])
        $display("FAIL flush_stall[%0d] got %b%b want %b%b",
                 c, o_st1, o_st2, ch[c], ~ch[c]);
      else passed++;
    end
  endtask

  task automatic test_error();
    @(negedge clk);
    resp = 1;
    @(negedge clk);
    resp = 0;
    #1;
    total++;
    if (o_err !== 1'b1 || o_out !== 4'd0)
      $display("FAIL err_set got err=%b out=%0d want 1/0", o_err, o_out);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (o_err !== 1'b1) $display("FAIL err_sticky got %b want 1", o_err);
    else passed++;
    @(negedge clk);
    rst = 0;
    #1;
    total++;
    if (o_err !== 1'b0) $display("FAIL err_in_rst got %b want 0", o_err);
    else passed++;
    @(negedge clk);
    rst = 1;
    #1;
    total++;
    if (o_err !== 1'b0) $display("FAIL err_cleared got %b want 0", o_err);
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    v1 = 0; v2 = 1; resp = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      v1 = 1; v2 = 1;
      #1;
      total++;
      if (o_choice !== 1'b0)
        $display("FAIL mid_pre[%0d] got %b want 0", i, o_choice);
      else passed++;
    end
    @(negedge clk);
    v1 = 0; v2 = 0;
    #1;
    total++;
    if (o_out !== 4'd3) $display("FAIL mid_outst got %0d want 3", o_out);
    else passed++;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1; v1 = 1; v2 = 1;
    #1;
    total++;
    if (o_out !== 4'd0) $display("FAIL mid_rst_outst got %0d want 0", o_out);
    else passed++;
    total++;
    if (o_valid !== 1'b1 || o_choice !== 1'b0)
      $display("FAIL mid_first_grant got v=%b c=%b want 1/0", o_valid, o_choice);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 0;
    idle_inputs();
    test_reset();
    test_weights();
    test_reset();
    test_only_p2();
    test_reset();
    test_credit();
    test_reset();
    test_flush();
    test_reset();
    test_error();
    test_reset();
    test_reset_mid();
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
